// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern generator and the sequence
// detector FSMs it drives: state encoding and default pattern geometry.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int   MAX_LEN_DEF  = 16;
    localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (register fills with IDLE_BIT)
//   load  - load data, left-justified so that data[len-1] appears on msb
//   shift - advance one bit toward msb, filling with IDLE_BIT
//   data  - parallel pattern word
//   len   - number of valid bits in data (1..MAX_LEN)
//   msb   - current serial bit (a flop output)
module piso_shift #(
    parameter int   MAX_LEN  = 16,
    parameter int   LEN_W    = $clog2(MAX_LEN + 1),
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] data,
    input  logic [LEN_W-1:0]   len,
    output logic               msb
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] sr_q;
    logic [MAX_LEN-1:0] load_val;
    logic [LEN_W-1:0]   shamt;

    // Bits below the pattern are pre-filled with IDLE_BIT so that once the
    // whole pattern has been shifted out, msb naturally rests at IDLE_BIT.
    always_comb begin
        shamt    = MAX_LEN_L - len;
        load_val = (data << shamt) | ({MAX_LEN{IDLE_BIT}} >> len);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {MAX_LEN{IDLE_BIT}};
        end else if (load) begin
            sr_q <= load_val;
        end else if (shift) begin
            sr_q <= {sr_q[MAX_LEN-2:0], IDLE_BIT};
        end
    end

    assign msb = sr_q[MAX_LEN-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter feeding the X input of sequence detectors.
// Captures pattern/length/repeat_n on start and sends the pattern MSB-first,
// back-to-back, repeat_n+1 times.
// Ports:
//   clk      - clock, rising edge
//   RESET    - synchronous active-high reset
//   start    - request pulse, honoured only in IDLE
//   pattern  - bits to send, pattern[length-1] first
//   length   - bits per repetition (clamped to MAX_LEN, 0 = empty stream)
//   repeat_n - extra repetitions
//   X        - serial data bit (IDLE_BIT when not valid)
//   valid    - X carries a pattern bit
//   busy     - stream in progress
//   done     - one-cycle pulse after the last bit
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | driving pattern bits, one per clock
// DONE  | one-cycle completion pulse, start ignored
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int   MAX_LEN  = MAX_LEN_DEF,
    parameter int   LEN_W    = $clog2(MAX_LEN + 1),
    parameter int   REP_W    = 4,
    parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [REP_W-1:0]   repeat_n,
    output logic               X,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               valid_q, busy_q, done_q;

    logic [LEN_W-1:0]   len_clamp;
    logic               sr_load, sr_shift;
    logic [MAX_LEN-1:0] sr_data;
    logic [LEN_W-1:0]   sr_len;

    assign len_clamp = (length > MAX_LEN_L) ? MAX_LEN_L : length;

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        reps_d   = reps_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = pat_q;
        sr_len   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        pat_d   = pattern;
                        len_d   = len_clamp;
                        cnt_d   = len_clamp - LEN_W'(1);
                        reps_d  = repeat_n;
                        sr_load = 1'b1;
                        sr_data = pattern;
                        sr_len  = len_clamp;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (reps_q != '0) begin
                        // Reload on the last bit so the next repetition
                        // follows without a gap cycle.
                        reps_d  = reps_q - REP_W'(1);
                        cnt_d   = len_q - LEN_W'(1);
                        sr_load = 1'b1;
                    end else begin
                        sr_shift = 1'b1;
                        state_d  = DONE;
                    end
                end else begin
                    cnt_d    = cnt_q - LEN_W'(1);
                    sr_shift = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            reps_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            reps_q  <= reps_d;
            valid_q <= (state_d == SHIFT);
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    piso_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .IDLE_BIT(IDLE_BIT)
    ) u_piso (
        .clk  (clk),
        .rst  (RESET),
        .load (sr_load),
        .shift(sr_shift),
        .data (sr_data),
        .len  (sr_len),
        .msb  (X)
    );

    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: inputs driven and outputs sampled
// on the falling edge, expected streams written out by hand.
module tb_serial_pattern_gen;

    logic        clk;
    logic        RESET;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [3:0]  repeat_n;
    logic        X, valid, busy, done;

    int n_cmp;
    int n_err;

    serial_pattern_gen dut (
        .clk     (clk),
        .RESET   (RESET),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .repeat_n(repeat_n),
        .X       (X),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".X"},     X,     1'b0);
        check_val({tag, ".valid"}, valid, 1'b0);
        check_val({tag, ".busy"},  busy,  1'b0);
        check_val({tag, ".done"},  done,  1'b0);
    endtask

    // Pulses start for one cycle; returns at cycle 1 after acceptance.
    task automatic send(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
        pattern  = p;
        length   = l;
        repeat_n = r;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Checks n bits (bits[n-1] first), then the done cycle and return to idle.
    // If poke > 0, a conflicting start is pulsed during cycle 'poke'.
    task automatic expect_stream(input string tag, input logic [63:0] bits, input int n, input int poke);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s.X[%0d]", tag, i), X, bits[n-1-i]);
            check_val($sformatf("%s.valid[%0d]", tag, i), valid, 1'b1);
            check_val($sformatf("%s.busy[%0d]", tag, i), busy, 1'b1);
            check_val($sformatf("%s.done[%0d]", tag, i), done, 1'b0);
            if (i + 1 == poke) begin
                pattern  = 16'hFFFF;
                length   = 5'd16;
                repeat_n = 4'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, ".done"},      done,  1'b1);
        check_val({tag, ".done_valid"}, valid, 1'b0);
        check_val({tag, ".done_busy"}, busy,  1'b0);
        check_val({tag, ".done_X"},    X,     1'b0);
        @(negedge clk);
        check_idle({tag, ".after"});
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        RESET    = 1'b1;
        start    = 1'b1;
        pattern  = 16'h001E;
        length   = 5'd5;
        repeat_n = 4'd0;

        // 1: reset held with start asserted
        @(negedge clk);
        check_idle("rst1");
        @(negedge clk);
        check_idle("rst2");
        RESET = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("rst_rel");

        // 2: single pattern 11110
        send(16'h001E, 5'd5, 4'd0);
        expect_stream("single", 64'b11110, 5, 0);

        // 3: 101 three times, contiguous
        send(16'h0005, 5'd3, 4'd2);
        expect_stream("repeat", 64'b101101101, 9, 0);

        // 4: start during the stream is ignored
        send(16'h001E, 5'd5, 4'd0);
        expect_stream("busy_start", 64'b11110, 5, 3);
        @(negedge clk);
        check_idle("busy_start.no2nd");

        // 5: reset mid-stream, 0xAA = 10101010
        send(16'h00AA, 5'd8, 4'd0);
        check_val("rstmid.X1", X, 1'b1);
        @(negedge clk);
        check_val("rstmid.X2", X, 1'b0);
        @(negedge clk);
        check_val("rstmid.X3", X, 1'b1);
        check_val("rstmid.valid3", valid, 1'b1);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        check_idle("rstmid.abort");
        @(negedge clk);
        check_idle("rstmid.nodone");
        send(16'h001E, 5'd5, 4'd0);
        expect_stream("rstmid.resend", 64'b11110, 5, 0);

        // 6a: length 0 -> done on cycle 1, never valid
        send(16'h00FF, 5'd0, 4'd0);
        check_val("len0.done",  done,  1'b1);
        check_val("len0.valid", valid, 1'b0);
        check_val("len0.busy",  busy,  1'b0);
        check_val("len0.X",     X,     1'b0);
        @(negedge clk);
        check_idle("len0.after");

        // 6b: length 20 clamps to 16
        send(16'h8001, 5'd20, 4'd0);
        expect_stream("clamp", 64'h8001, 16, 0);

        // repeat_n all-ones gives 16 repetitions, no wrap
        send(16'h0001, 5'd1, 4'd15);
        expect_stream("rep_max", 64'hFFFF, 16, 0);

        // full-width pattern repeated twice
        send(16'hC3A5, 5'd16, 4'd1);
        expect_stream("full_rep", 64'hC3A5C3A5, 32, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
